// File: rtl/hdd_pkg.sv
// -----------------------------------------------------------------------------
// hdd_pkg
// Definitions shared by the HDD register block and the sector transfer
// sequencer (hdd_xfer_ctrl). They live here so that both sides agree on the
// encodings.
//   xfer_state_e  : sequencer states
//   xfer_dir_e    : transfer direction (read = host -> buffer)
//   SECTOR_BYTES  : bytes per sector
//   NO_DEVICE,
//   PROTECT       : ProDOS status codes reported by the register block
// -----------------------------------------------------------------------------
package hdd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_XFER = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } xfer_state_e;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } xfer_dir_e;

  localparam int SECTOR_BYTES = 512;

  localparam logic [7:0] NO_DEVICE = 8'h28;
  localparam logic [7:0] PROTECT   = 8'h2B;

endpackage

// File: rtl/hdd_xfer_ctrl_if.sv
// -----------------------------------------------------------------------------
// hdd_xfer_ctrl_if
// Host block-device bundle between the transfer sequencer and the top-level
// disk plumbing.
//   sd_lba        : host LBA                        (sequencer -> host)
//   sd_rd, sd_wr  : read / write requests           (sequencer -> host)
//   sd_ack        : host owns the transfer while high (host -> sequencer)
//   sd_buff_addr  : host byte index                 (host -> sequencer)
//   sd_buff_dout  : host -> buffer data             (host -> sequencer)
//   sd_buff_wr    : host -> buffer write strobe     (host -> sequencer)
//   sd_buff_din   : buffer -> host data             (sequencer -> host)
// The master modport is the sequencer side; the slave modport is the host side.
// -----------------------------------------------------------------------------
interface hdd_xfer_ctrl_if;

  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

endinterface

// File: rtl/hdd_timeout_ctr.sv
// -----------------------------------------------------------------------------
// hdd_timeout_ctr
// Down-counter that bounds how long the sequencer waits for the host to
// acknowledge a request.
//   clk_i   : clock
//   load_i  : load LOAD_VAL (takes priority over dec_i)
//   dec_i   : count down by one; holds at zero
//   zero_o  : counter is zero
// The count is always loaded before it is used, so it carries no reset.
// -----------------------------------------------------------------------------
module hdd_timeout_ctr #(
  parameter int          W        = 24,
  parameter logic [W-1:0] LOAD_VAL = '0
) (
  input  logic clk_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hdd_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// hdd_xfer_ctrl
// Services the HDD block's one-cycle read/write strobes. It moves one 512-byte
// sector between the host block-device interface and the second port of the
// HDD sector buffer, and it holds the CPU halted while the transfer runs.
//   CLK_14M, RESET_N   : clock, synchronous active-low reset
//   hdd_read/hdd_write : one-cycle sector strobes; sector is sampled with them
//   hdd_mounted        : an image is present
//   sd                 : host block-device bundle (master side)
//   ram_addr/di/we/do  : sector buffer port (ram_do has 1-cycle latency)
//   cpu_halt           : high through REQ and XFER
//   busy               : sequencer not idle
//   done               : one-cycle completion pulse (success or error)
//   error              : sticky error of the last command
//   overrun            : sticky, a strobe arrived while busy
// -----------------------------------------------------------------------------
module hdd_xfer_ctrl
  import hdd_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_400_000,
  parameter logic [31:0] LBA_BASE    = 32'd0
) (
  input  logic            CLK_14M,
  input  logic            RESET_N,
  input  logic            hdd_read,
  input  logic            hdd_write,
  input  logic [15:0]     sector,
  input  logic            hdd_mounted,
  hdd_xfer_ctrl_if.master sd,
  output logic [8:0]      ram_addr,
  output logic [7:0]      ram_di,
  output logic            ram_we,
  input  logic [7:0]      ram_do,
  output logic            cpu_halt,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic            overrun
);

  xfer_state_e state_q, state_d;
  xfer_dir_e   dir_q, dir_d;
  logic [31:0] lba_q, lba_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  cnt_inc;
  logic [7:0]  din_q, din_d;
  logic        error_q, error_d;
  logic        overrun_q, overrun_d;
  logic        strobe;
  logic        tmo_load;
  logic        tmo_dec;
  logic        tmo_zero;
  logic        in_xfer;
  logic        xfer_rd;

  assign strobe  = hdd_read | hdd_write;
  assign in_xfer = (state_q == ST_XFER);
  assign xfer_rd = in_xfer && (dir_q == DIR_READ);
  // The pulse that coincides with the falling edge of ack still counts.
  assign cnt_inc = cnt_q + {9'd0, sd.sd_buff_wr};

  assign tmo_load = (state_q == ST_IDLE) && strobe;
  assign tmo_dec  = (state_q == ST_REQ) && !sd.sd_ack;

  hdd_timeout_ctr #(
    .W        (24),
    .LOAD_VAL (TIMEOUT_CYC)
  ) u_tmo (
    .clk_i  (CLK_14M),
    .load_i (tmo_load),
    .dec_i  (tmo_dec),
    .zero_o (tmo_zero)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    lba_d     = lba_q;
    cnt_d     = cnt_q;
    din_d     = din_q;
    error_d   = error_q;
    overrun_d = overrun_q | (strobe && (state_q != ST_IDLE));

    unique case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          // A read wins over a simultaneous write, and the write is dropped.
          dir_d   = hdd_read ? DIR_READ : DIR_WRITE;
          lba_d   = LBA_BASE + {16'h0, sector};
          error_d = 1'b0;
          if (hdd_mounted) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (sd.sd_ack) begin
          state_d = ST_XFER;
          cnt_d   = '0;
        end else if (tmo_zero) begin
          state_d = ST_ERR;
          error_d = 1'b1;
        end
      end
      ST_XFER: begin
        // Remember the last byte seen by the host so it holds after XFER.
        din_d = ram_do;
        cnt_d = cnt_inc;
        if (!sd.sd_ack) begin
          if ((dir_q == DIR_READ) && (cnt_inc != 10'(SECTOR_BYTES))) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_14M) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      lba_q     <= '0;
      din_q     <= '0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      din_q     <= din_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge CLK_14M) begin
    dir_q <= dir_d;
    cnt_q <= cnt_d;
  end

  // Requests and halt decode straight from the state register, so they
  // drop on the edge that leaves REQ and on any reset edge.
  assign sd.sd_lba      = lba_q;
  assign sd.sd_rd       = (state_q == ST_REQ) && (dir_q == DIR_READ);
  assign sd.sd_wr       = (state_q == ST_REQ) && (dir_q == DIR_WRITE);
  assign sd.sd_buff_din = in_xfer ? ram_do : din_q;

  assign ram_addr = in_xfer ? sd.sd_buff_addr : 9'd0;
  assign ram_we   = xfer_rd && sd.sd_buff_wr;
  assign ram_di   = xfer_rd ? sd.sd_buff_dout : 8'd0;

  assign cpu_halt = (state_q == ST_REQ) || in_xfer;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign error    = error_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_hdd_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hdd_xfer_ctrl
// Directed and randomized bench for hdd_xfer_ctrl. It keeps a sector buffer
// RAM with registered read data, and a model of what the buffer should hold.
// -----------------------------------------------------------------------------
module tb_hdd_xfer_ctrl;
  import hdd_pkg::*;

  localparam logic [23:0] TMO  = 24'd16;
  localparam logic [31:0] BASE = 32'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hdd_read, hdd_write, hdd_mounted;
  logic [15:0] sector;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_di, ram_do;
  logic        ram_we, cpu_halt, busy, done, error, overrun;

  hdd_xfer_ctrl_if sd_if();

  always #5 clk = ~clk;

  hdd_xfer_ctrl #(
    .TIMEOUT_CYC (TMO),
    .LBA_BASE    (BASE)
  ) dut (
    .CLK_14M     (clk),
    .RESET_N     (rst_n),
    .hdd_read    (hdd_read),
    .hdd_write   (hdd_write),
    .sector      (sector),
    .hdd_mounted (hdd_mounted),
    .sd          (sd_if),
    .ram_addr    (ram_addr),
    .ram_di      (ram_di),
    .ram_we      (ram_we),
    .ram_do      (ram_do),
    .cpu_halt    (cpu_halt),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .overrun     (overrun)
  );

  // Sector buffer second port: synchronous write, registered read.
  logic [7:0] ram [0:511];
  int         we_total = 0;
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_di;
    ram_do <= ram[ram_addr];
    if (ram_we) we_total <= we_total + 1;
  end

  // Expected buffer contents.
  logic [7:0] mem [0:511];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic strobe(input logic rd, input logic wr, input logic [15:0] sec);
    sector    = sec;
    hdd_read  = rd;
    hdd_write = wr;
    step();
    hdd_read  = 1'b0;
    hdd_write = 1'b0;
  endtask

  task automatic read_xfer(input logic [15:0] sec, input int nbytes,
                           input bit both, input bit poke);
    int         i;
    int         we0;
    logic [7:0] d;
    strobe(1'b1, both, sec);
    chk("rd_req", sd_if.sd_rd, 1);
    chk("rd_no_wr", sd_if.sd_wr, 0);
    chk("rd_lba", sd_if.sd_lba, BASE + {16'h0, sec});
    chk("rd_halt", cpu_halt, 1);
    chk("rd_err_clr", error, 0);
    repeat ($urandom_range(0, 4)) step();
    chk("rd_req_hold", sd_if.sd_rd, 1);
    sd_if.sd_ack = 1'b1;
    step();
    chk("rd_req_drop", sd_if.sd_rd, 0);
    chk("rd_halt_xfer", cpu_halt, 1);
    we0 = we_total;
    i = 0;
    while (i < nbytes) begin
      if (poke && i == 10) hdd_write = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        sd_if.sd_buff_wr = 1'b0;
        #1 chk("rd_we_gap", ram_we, 0);
      end else begin
        d = 8'($urandom);
        sd_if.sd_buff_addr = 9'(i);
        sd_if.sd_buff_dout = d;
        sd_if.sd_buff_wr   = 1'b1;
        mem[i] = d;
        #1;
        chk("rd_we", ram_we, 1);
        chk("rd_addr", ram_addr, i);
        chk("rd_di", ram_di, d);
        i++;
      end
      step();
      hdd_write = 1'b0;
    end
    sd_if.sd_buff_wr = 1'b0;
    sd_if.sd_ack     = 1'b0;
    step();
    chk("rd_done", done, 1);
    chk("rd_error", error, (nbytes != SECTOR_BYTES) ? 1 : 0);
    chk("rd_halt_low", cpu_halt, 0);
    chk("rd_ram_addr_idle", ram_addr, 0);
    if (poke) chk("rd_overrun", overrun, 1);
    step();
    chk("rd_done_once", done, 0);
    chk("rd_busy_low", busy, 0);
    chk("rd_we_count", we_total - we0, nbytes);
  endtask

  task automatic write_xfer(input logic [15:0] sec);
    int we0;
    strobe(1'b0, 1'b1, sec);
    chk("wr_req", sd_if.sd_wr, 1);
    chk("wr_no_rd", sd_if.sd_rd, 0);
    chk("wr_lba", sd_if.sd_lba, BASE + {16'h0, sec});
    sd_if.sd_ack = 1'b1;
    step();
    chk("wr_req_drop", sd_if.sd_wr, 0);
    we0 = we_total;
    for (int i = 0; i < 512; i++) begin
      sd_if.sd_buff_addr = 9'(i);
      sd_if.sd_buff_dout = 8'($urandom);
      sd_if.sd_buff_wr   = 1'($urandom);
      #1;
      chk("wr_addr", ram_addr, i);
      chk("wr_no_we", ram_we, 0);
      step();
      chk("wr_din", sd_if.sd_buff_din, mem[i]);
    end
    sd_if.sd_buff_wr = 1'b0;
    sd_if.sd_ack     = 1'b0;
    step();
    chk("wr_done", done, 1);
    chk("wr_error", error, 0);
    chk("wr_halt_low", cpu_halt, 0);
    chk("wr_din_hold", sd_if.sd_buff_din, mem[511]);
    step();
    chk("wr_done_once", done, 0);
    chk("wr_din_hold2", sd_if.sd_buff_din, mem[511]);
    chk("wr_we_count", we_total - we0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_lba"}, sd_if.sd_lba, 0);
    chk({tag, "_rd"}, sd_if.sd_rd, 0);
    chk({tag, "_wr"}, sd_if.sd_wr, 0);
    chk({tag, "_din"}, sd_if.sd_buff_din, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_di"}, ram_di, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_halt"}, cpu_halt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: observed no finish expected finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n              = 1'b0;
    hdd_read           = 1'b0;
    hdd_write          = 1'b0;
    hdd_mounted        = 1'b1;
    sector             = 16'h0;
    sd_if.sd_ack       = 1'b0;
    sd_if.sd_buff_addr = 9'h0;
    sd_if.sd_buff_dout = 8'h0;
    sd_if.sd_buff_wr   = 1'b0;
    repeat (3) step();
    check_reset_values("rst");
    rst_n = 1'b1;
    step();

    // Directed read of sector 0x0123, then write it back to the host.
    read_xfer(16'h0123, 512, 1'b0, 1'b0);
    chk("overrun_clear", overrun, 0);
    write_xfer(16'h0123);

    // Randomized mix of full reads, short reads and writes.
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 2) == 0)
        read_xfer(16'($urandom), $urandom_range(1, 511), 1'b0, 1'b0);
      else
        read_xfer(16'($urandom), 512, 1'b0, 1'b0);
      write_xfer(16'($urandom));
    end

    // Short read: 300 bytes then ack falls.
    read_xfer(16'h0042, 300, 1'b0, 1'b0);
    write_xfer(16'h0042);

    // Timeout with no ack.
    strobe(1'b1, 1'b0, 16'h0007);
    chk("tmo_req", sd_if.sd_rd, 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("tmo_hold", sd_if.sd_rd, 1);
    end
    step();
    chk("tmo_rd_drop", sd_if.sd_rd, 0);
    chk("tmo_error", error, 1);
    chk("tmo_done", done, 1);
    step();
    chk("tmo_idle", busy, 0);

    // Strobe with no image mounted.
    hdd_mounted = 1'b0;
    strobe(1'b1, 1'b0, 16'h0009);
    chk("unm_no_rd", sd_if.sd_rd, 0);
    chk("unm_error", error, 1);
    chk("unm_done", done, 1);
    chk("unm_halt", cpu_halt, 0);
    step();
    chk("unm_done_once", done, 0);
    chk("unm_idle", busy, 0);
    hdd_mounted = 1'b1;

    // Simultaneous strobes: read only.
    read_xfer(16'hBEEF, 512, 1'b1, 1'b0);
    chk("coll_no_overrun", overrun, 0);

    // Strobe during XFER sets overrun.
    read_xfer(16'hFFFF, 512, 1'b0, 1'b1);

    // Reset for one cycle in the middle of a transfer.
    strobe(1'b1, 1'b0, 16'h0101);
    sd_if.sd_ack = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      sd_if.sd_buff_addr = 9'(i);
      sd_if.sd_buff_dout = 8'($urandom);
      sd_if.sd_buff_wr   = 1'b1;
      mem[i] = sd_if.sd_buff_dout;
      step();
    end
    sd_if.sd_buff_wr = 1'b0;
    rst_n = 1'b0;
    step();
    check_reset_values("mid_rst");
    rst_n        = 1'b1;
    sd_if.sd_ack = 1'b0;
    step();
    chk("post_rst_idle", busy, 0);

    // Buffer holds the 20 bytes written before the reset.
    write_xfer(16'h0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hdd_xfer_ctrl.md
# hdd_xfer_ctrl

Sequencer that services the HDD block's one-cycle `hdd_read`/`hdd_write` strobes. It moves one 512-byte sector between the host block-device interface (`sd_*`) and the HDD sector buffer's second port (`ram_*`). It also holds the CPU halted for the duration of each transfer. It sits between the HDD register interface and the top-level host-disk plumbing, and owns LBA formation, request/acknowledge handshaking, byte counting and timeout.

## Interface
Parameters:
- `TIMEOUT_CYC`, 24'd1_400_000: cycles to wait for `sd_ack` after a request before declaring an error (~100 ms at 14 MHz).
- `LBA_BASE`, 32'd0: offset added to the 16-bit block number.

Ports:
- `CLK_14M` in 1: system clock; the only clock.
- `RESET_N` in 1: reset, synchronous, active-low.
- `hdd_read` in 1: one-cycle read-sector strobe.
- `hdd_write` in 1: one-cycle write-sector strobe.
- `sector` in 16: block number, sampled on the strobe.
- `hdd_mounted` in 1: an image is present.
- `sd_lba` out 32: host LBA.
- `sd_rd` out 1: host read request.
- `sd_wr` out 1: host write request.
- `sd_ack` in 1: host owns the transfer while high.
- `sd_buff_addr` in 9: host byte index.
- `sd_buff_dout` in 8: host→buffer data.
- `sd_buff_wr` in 1: host→buffer write strobe.
- `sd_buff_din` out 8: buffer→host data.
- `ram_addr` out 9: sector buffer port address.
- `ram_di` out 8: sector buffer port write data.
- `ram_we` out 1: sector buffer port write enable.
- `ram_do` in 8: sector buffer port read data, registered (1-cycle latency).
- `cpu_halt` out 1: stall the CPU.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: sticky error of the last command.
- `overrun` out 1: sticky flag; a strobe arrived while busy.

## Operation
- States: IDLE, REQ, XFER, DONE, ERR.
- **IDLE**
  - On `hdd_read` or `hdd_write`: latch direction and `sd_lba = LBA_BASE + {16'h0, sector}` (32-bit, wraps modulo 2^32), clear `error`, and go to REQ.
  - If `hdd_mounted=0` at the strobe: go to ERR instead.
  - Simultaneous read and write strobes: read wins, and the write is dropped.
- **REQ**
  - Drive `sd_rd` or `sd_wr` to 1 and `cpu_halt` to 1.
  - Load the timeout counter with `TIMEOUT_CYC`.
  - On `sd_ack=1`: drop the request and go to XFER.
  - When the counter reaches 0: go to ERR.
- **XFER**
  - `ram_addr = sd_buff_addr` combinationally, and `sd_buff_din = ram_do`.
  - Read direction only: `ram_we = sd_buff_wr` and `ram_di = sd_buff_dout`. A 10-bit counter counts `sd_buff_wr` pulses.
  - On `sd_ack` falling: go to DONE. If this is a read and the count ≠ 512, go to ERR instead.
- **DONE**: pulse `done` for one cycle, then go to IDLE.
- **ERR**: hold request lines at 0, set `error=1`, pulse `done`, then go to IDLE.
- A strobe arriving in any state other than IDLE sets `overrun`. It is cleared only by reset.
- Outside XFER: `ram_we=0`, `ram_addr=0`, and `sd_buff_din` holds its last value.

## Timing
- Reset values: `sd_lba=0`, `sd_rd=0`, `sd_wr=0`, `sd_buff_din=0`, `ram_addr=0`, `ram_di=0`, `ram_we=0`, `cpu_halt=0`, `busy=0`, `done=0`, `error=0`, `overrun=0`; state IDLE.
- Reset asserted in any state returns to IDLE on the next edge and drops all requests. A host transfer in flight is abandoned.
- Strobe at edge N: state REQ at N+1, with `sd_rd`/`sd_wr`, `cpu_halt` and `sd_lba` all valid from N+1.
- `sd_ack` seen high at edge M: request deasserts at M+1.
- Host write data: `sd_buff_din` is valid one cycle after `sd_buff_addr` is presented. The host tolerates 1-cycle read latency.
- Host read data: `ram_we` follows `sd_buff_wr` with zero added latency.
- `cpu_halt` covers every cycle of REQ and XFER, and falls in the cycle `done` pulses.
- Timeout: ERR is entered exactly `TIMEOUT_CYC`+1 cycles after REQ entry when `sd_ack` never rises.

## Structure
- Shared package `hdd_pkg` holds:
  - state enum
  - `SECTOR_BYTES=512`
  - direction enum
  - ProDOS status constants (`NO_DEVICE` 8'h28, `PROTECT` 8'h2B), so the register block and this controller agree.
- No sub-module is needed. Optionally factor the timeout counter as `hdd_timeout_ctr`.

## Test plan
- **Read path:** `sector=16'h0123` and a read strobe. Expect `sd_rd=1` and `sd_lba=32'h0123` at N+1. Ack, stream 512 bytes of `addr[7:0]`, drop ack. Expect `ram_we` asserted 512 times, `done` pulsed, `error=0`, and `cpu_halt` low after DONE.
- **Write path:** write strobe, ack, then step `sd_buff_addr` 0..511. Expect `sd_buff_din` to equal the preloaded buffer byte one cycle later, `ram_we` never asserted, and `sd_wr` to fall the cycle after ack.
- **Short read:** ack falls after 300 `sd_buff_wr` pulses. Expect ERR, `error=1`, and a `done` pulse.
- **Timeout:** `TIMEOUT_CYC=16` with no ack. Expect `sd_rd` to drop and `error=1` 17 cycles after REQ entry.
- **Unmounted / collision:** strobe with `hdd_mounted=0` gives `error=1` and no `sd_rd`. Simultaneous read and write strobes issue only `sd_rd`. A strobe during XFER sets `overrun`.
- **Reset mid-XFER:** `RESET_N=0` for 1 cycle. All outputs return to their reset values on the next edge.
